// File: rtl/fpmult_accumulator_if.sv
// Product-stream / dot-product-result bundle for fpmult_accumulator.
//   recv_*  : product beats from the multiplier (val/rdy, last closes a burst)
//   send_*  : saturated burst sum, saturation flag and beat count (val/rdy)
// Modports:
//   master : the surrounding system (drives beats, consumes results)
//   slave  : the accumulator
interface fpmult_accumulator_if #(
  parameter int n = 32,
  parameter int g = 8
);
  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] recv_msg;
  logic         recv_last;

  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] send_msg;
  logic         send_sat;
  logic [g:0]   send_cnt;

  modport master (
    output recv_val, recv_msg, recv_last, send_rdy,
    input  recv_rdy, send_val, send_msg, send_sat, send_cnt
  );

  modport slave (
    input  recv_val, recv_msg, recv_last, send_rdy,
    output recv_rdy, send_val, send_msg, send_sat, send_cnt
  );
endinterface

// File: rtl/fpmult_accumulator.sv
// Sums a 'last'-delimited burst of n-bit fixed-point products into one
// saturated n-bit dot-product result with a saturating beat count.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : fpmult_accumulator_if.slave (recv_* beats in, send_* result out)
// Parameters: n data width, d fractional bits (format only), sign
// (1 = two's complement, 0 = unsigned), g accumulator guard bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// ACCUM | accepting beats, accumulating into acc
// DONE  | result presented on send_*, held until send_rdy
module fpmult_accumulator #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1,
  parameter int g    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fpmult_accumulator_if.slave  bus
);

  localparam int aw = n + g;

  // The binary point never moves through a sum, so d only has to be sane.
  if (d < 0 || d > n) begin : g_bad_frac
    $error("fpmult_accumulator: d must lie within [0, n]");
  end

  typedef enum logic {ACCUM, DONE} state_t;

  state_t        state;
  state_t        state_next;

  logic [aw-1:0] acc;
  logic [g:0]    cnt;
  logic          sat_sticky;

  logic          accept;
  logic [aw-1:0] ext_msg;
  logic [aw:0]   sum_wide;
  logic [aw-1:0] acc_sum;
  logic          acc_clamp;
  logic [n-1:0]  res_msg;
  logic          res_clamp;
  logic [g:0]    cnt_inc;

  // Ready is held low through reset, so accept is derived from state and
  // reset directly rather than from the ready output.
  assign accept = bus.recv_val && (state == ACCUM) && !reset;

  always_comb begin
    ext_msg   = '0;
    sum_wide  = '0;
    acc_sum   = '0;
    acc_clamp = 1'b0;
    res_msg   = '0;
    res_clamp = 1'b0;

    if (sign != 0) begin
      ext_msg  = {{g{bus.recv_msg[n-1]}}, bus.recv_msg};
      sum_wide = {acc[aw-1], acc} + {ext_msg[aw-1], ext_msg};
      acc_sum  = sum_wide[aw-1:0];
      // Signed overflow: the extra carry bit disagrees with the result sign.
      if (sum_wide[aw] != sum_wide[aw-1]) begin
        acc_clamp = 1'b1;
        acc_sum   = sum_wide[aw] ? {1'b1, {(aw-1){1'b0}}} : {1'b0, {(aw-1){1'b1}}};
      end
      res_msg = acc_sum[n-1:0];
      // Fits in n bits only if the guard bits are copies of the n-bit sign.
      if (acc_sum[aw-1:n-1] != {(g+1){acc_sum[aw-1]}}) begin
        res_clamp = 1'b1;
        res_msg   = acc_sum[aw-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      end
    end else begin
      ext_msg  = {{g{1'b0}}, bus.recv_msg};
      sum_wide = {1'b0, acc} + {1'b0, ext_msg};
      acc_sum  = sum_wide[aw-1:0];
      if (sum_wide[aw]) begin
        acc_clamp = 1'b1;
        acc_sum   = '1;
      end
      res_msg = acc_sum[n-1:0];
      if (acc_sum[aw-1:n] != '0) begin
        res_clamp = 1'b1;
        res_msg   = '1;
      end
    end
  end

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    bus.recv_rdy = 1'b0;
    bus.send_val = 1'b0;
    case (state)
      ACCUM: begin
        bus.recv_rdy = !reset;
        if (accept && bus.recv_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.send_val = 1'b1;
        if (bus.send_rdy) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      sat_sticky   <= 1'b0;
      bus.send_msg <= '0;
      bus.send_sat <= 1'b0;
      bus.send_cnt <= '0;
    end else if (accept) begin
      acc        <= acc_sum;
      cnt        <= cnt_inc;
      sat_sticky <= sat_sticky | acc_clamp;
      // The closing beat is already folded into the result it is loaded with.
      if (bus.recv_last) begin
        bus.send_msg <= res_msg;
        bus.send_sat <= sat_sticky | acc_clamp | res_clamp;
        bus.send_cnt <= cnt_inc;
      end
    end else if (state == DONE && bus.send_rdy) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
    end
  end

endmodule
